// File: rtl/icepic_fetch_unit.sv
// Fetch/PC stage of the iCEPIC baseline core. It drives the program-memory port and holds the 2-level call stack.
// Latency: one cycle from address to execute slot. Any redirect or skip inserts one bubble. stall freezes the whole stage.
module icepic_fetch_unit #(
    parameter int                  PC_WIDTH     = 9,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 9'h1FF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_en,
    input  logic [11:0]         imem_rdata,
    output logic [11:0]         inst_out,
    output logic                inst_valid,
    output logic [PC_WIDTH-1:0] exec_pc,
    input  logic [1:0]          pc_update_sel,
    input  logic                jump_is_call,
    input  logic [PC_WIDTH-1:0] jump_addr,
    input  logic [7:0]          pcl_wdata,
    input  logic                skip
);

    typedef enum logic [1:0] {
        SEL_INC     = 2'd0,
        SEL_JUMP    = 2'd1,
        SEL_RET     = 2'd2,
        SEL_PCL_MOD = 2'd3
    } pc_update_sel_t;

    logic [PC_WIDTH-1:0] fetch_pc;
    logic                flush_q;
    logic [PC_WIDTH-1:0] stack1;
    logic [PC_WIDTH-1:0] stack2;

    pc_update_sel_t      sel_q;
    logic                call_q;
    logic                skip_q;
    logic                redirect;
    logic                skip_eff;
    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] stack1_nxt;
    logic [PC_WIDTH-1:0] stack2_nxt;

    assign imem_addr  = fetch_pc;
    assign imem_en    = ~stall;
    assign inst_valid = ~flush_q;
    assign inst_out   = flush_q ? 12'h000 : imem_rdata;

    // A flushed slot must not steer the PC, so its control inputs are replaced by a plain increment.
    always_comb begin
        sel_q  = inst_valid ? pc_update_sel_t'(pc_update_sel) : SEL_INC;
        call_q = inst_valid & jump_is_call;
        skip_q = inst_valid & skip;
    end

    assign redirect = (sel_q != SEL_INC);
    assign skip_eff = skip_q & (sel_q == SEL_INC);

    always_comb begin
        next_pc    = fetch_pc + PC_WIDTH'(1);
        stack1_nxt = stack1;
        stack2_nxt = stack2;
        case (sel_q)
            SEL_JUMP: begin
                if (call_q) begin
                    // A CALL can only reach the lower half of the page, as on the baseline PIC.
                    next_pc    = PC_WIDTH'(jump_addr[7:0]);
                    stack1_nxt = exec_pc + PC_WIDTH'(1);
                    stack2_nxt = stack1;
                end else begin
                    next_pc = jump_addr;
                end
            end
            SEL_RET: begin
                next_pc    = stack1;
                stack1_nxt = stack2;
            end
            SEL_PCL_MOD: next_pc = PC_WIDTH'(pcl_wdata);
            default:     next_pc = fetch_pc + PC_WIDTH'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_VECTOR;
            exec_pc  <= '0;
            flush_q  <= 1'b1;
            stack1   <= '0;
            stack2   <= '0;
        end else if (!stall) begin
            fetch_pc <= next_pc;
            exec_pc  <= fetch_pc;
            flush_q  <= redirect | skip_eff;
            stack1   <= stack1_nxt;
            stack2   <= stack2_nxt;
        end
    end

endmodule

// File: tb/tb_icepic_fetch_unit.sv
// Cycle-table bench for icepic_fetch_unit with a behavioural synchronous program memory.
module tb_icepic_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [8:0]  imem_addr;
    logic        imem_en;
    logic [11:0] imem_rdata;
    logic [11:0] inst_out;
    logic        inst_valid;
    logic [8:0]  exec_pc;
    logic [1:0]  pc_update_sel;
    logic        jump_is_call;
    logic [8:0]  jump_addr;
    logic [7:0]  pcl_wdata;
    logic        skip;

    int checks = 0;
    int errors = 0;

    icepic_fetch_unit #(.PC_WIDTH(9), .RESET_VECTOR(9'h1FF)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .imem_addr     (imem_addr),
        .imem_en       (imem_en),
        .imem_rdata    (imem_rdata),
        .inst_out      (inst_out),
        .inst_valid    (inst_valid),
        .exec_pc       (exec_pc),
        .pc_update_sel (pc_update_sel),
        .jump_is_call  (jump_is_call),
        .jump_addr     (jump_addr),
        .pcl_wdata     (pcl_wdata),
        .skip          (skip)
    );

    always #5 clk = ~clk;

    // Every word holds a unique tag of its own address, so inst_out reveals which word was fetched.
    function automatic logic [11:0] pat(input logic [8:0] a);
        return {3'b101, a};
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= pat(imem_addr);
    end

    typedef struct {
        logic       rst;
        logic       stall;
        logic [1:0] sel;
        logic       call;
        logic [8:0] ja;
        logic [7:0] pcl;
        logic       skp;
        logic       v;
        logic [8:0] epc;
        logic [8:0] addr;
    } vec_t;

    localparam logic [1:0] INC = 2'd0, JMP = 2'd1, RET = 2'd2, PCL = 2'd3;
    localparam int NV = 54;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic st, input logic [1:0] s, input logic c,
                                input logic [8:0] j, input logic [7:0] p, input logic sk,
                                input logic v, input logic [8:0] e, input logic [8:0] a);
        vec_t t;
        t.rst = r; t.stall = st; t.sel = s; t.call = c; t.ja = j; t.pcl = p; t.skp = sk;
        t.v = v; t.epc = e; t.addr = a;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic [1:0] s, input logic c,
                         input logic [8:0] j, input logic [7:0] p, input logic sk);
        rst = r; stall = st; pc_update_sel = s; jump_is_call = c; jump_addr = j; pcl_wdata = p; skip = sk;
    endtask

    task automatic check_outputs(input int idx, input logic st, input logic v,
                                 input logic [8:0] e, input logic [8:0] a);
        check("inst_valid", idx, {11'd0, inst_valid}, {11'd0, v});
        check("exec_pc",    idx, {3'd0, exec_pc},     {3'd0, e});
        check("imem_addr",  idx, {3'd0, imem_addr},   {3'd0, a});
        check("imem_en",    idx, {11'd0, imem_en},    {11'd0, ~st});
        check("inst_out",   idx, inst_out,            v ? pat(e) : 12'h000);
    endtask

    initial begin
        // Each row: inputs for this cycle, and the outputs expected before the next rising edge.
        vecs[0]  = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h000,9'h1FF);
        vecs[1]  = mk(0,0,INC,0,9'h000,8'h00,0, 1,9'h1FF,9'h000);
        vecs[2]  = mk(0,0,JMP,0,9'h005,8'h00,0, 1,9'h000,9'h001);
        vecs[3]  = mk(0,0,JMP,0,9'h077,8'h00,0, 0,9'h001,9'h005);
        vecs[4]  = mk(0,0,JMP,0,9'h123,8'h00,0, 1,9'h005,9'h006);
        vecs[5]  = mk(0,0,INC,0,9'h000,8'h00,1, 0,9'h006,9'h123);
        vecs[6]  = mk(0,0,JMP,0,9'h010,8'h00,0, 1,9'h123,9'h124);
        vecs[7]  = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h124,9'h010);
        vecs[8]  = mk(0,0,JMP,1,9'h1AB,8'h00,0, 1,9'h010,9'h011);
        vecs[9]  = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h011,9'h0AB);
        vecs[10] = mk(0,0,RET,0,9'h000,8'h00,0, 1,9'h0AB,9'h0AC);
        vecs[11] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h0AC,9'h011);
        vecs[12] = mk(0,0,JMP,0,9'h020,8'h00,0, 1,9'h011,9'h012);
        vecs[13] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h012,9'h020);
        vecs[14] = mk(0,0,JMP,1,9'h030,8'h00,0, 1,9'h020,9'h021);
        vecs[15] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h021,9'h030);
        vecs[16] = mk(0,0,JMP,1,9'h040,8'h00,0, 1,9'h030,9'h031);
        vecs[17] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h031,9'h040);
        vecs[18] = mk(0,0,JMP,1,9'h0C0,8'h00,0, 1,9'h040,9'h041);
        vecs[19] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h041,9'h0C0);
        vecs[20] = mk(0,0,RET,0,9'h000,8'h00,0, 1,9'h0C0,9'h0C1);
        vecs[21] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h0C1,9'h041);
        vecs[22] = mk(0,0,RET,0,9'h000,8'h00,0, 1,9'h041,9'h042);
        vecs[23] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h042,9'h031);
        vecs[24] = mk(0,0,RET,0,9'h000,8'h00,0, 1,9'h031,9'h032);
        vecs[25] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h032,9'h031);
        vecs[26] = mk(0,0,JMP,0,9'h050,8'h00,0, 1,9'h031,9'h032);
        vecs[27] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h032,9'h050);
        vecs[28] = mk(0,0,INC,0,9'h000,8'h00,1, 1,9'h050,9'h051);
        vecs[29] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h051,9'h052);
        vecs[30] = mk(0,0,JMP,0,9'h100,8'h00,1, 1,9'h052,9'h053);
        vecs[31] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h053,9'h100);
        vecs[32] = mk(0,0,INC,0,9'h000,8'h00,0, 1,9'h100,9'h101);
        vecs[33] = mk(0,0,JMP,0,9'h150,8'h00,0, 1,9'h101,9'h102);
        vecs[34] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h102,9'h150);
        vecs[35] = mk(0,0,PCL,0,9'h000,8'h80,0, 1,9'h150,9'h151);
        vecs[36] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h151,9'h080);
        vecs[37] = mk(0,0,INC,0,9'h000,8'h00,0, 1,9'h080,9'h081);
        vecs[38] = mk(0,1,JMP,0,9'h1F0,8'h00,0, 1,9'h081,9'h082);
        vecs[39] = mk(0,1,RET,0,9'h000,8'h00,1, 1,9'h081,9'h082);
        vecs[40] = mk(0,1,PCL,0,9'h000,8'h33,0, 1,9'h081,9'h082);
        vecs[41] = mk(0,0,INC,0,9'h000,8'h00,0, 1,9'h081,9'h082);
        vecs[42] = mk(0,0,JMP,0,9'h1FE,8'h00,0, 1,9'h082,9'h083);
        vecs[43] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h083,9'h1FE);
        vecs[44] = mk(0,0,INC,0,9'h000,8'h00,0, 1,9'h1FE,9'h1FF);
        vecs[45] = mk(0,0,INC,0,9'h000,8'h00,0, 1,9'h1FF,9'h000);
        vecs[46] = mk(0,0,JMP,1,9'h060,8'h00,0, 1,9'h000,9'h001);
        vecs[47] = mk(1,0,INC,0,9'h000,8'h00,0, 0,9'h001,9'h060);
        vecs[48] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h000,9'h1FF);
        vecs[49] = mk(0,0,RET,0,9'h000,8'h00,0, 1,9'h1FF,9'h000);
        vecs[50] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h000,9'h000);
        vecs[51] = mk(0,0,RET,0,9'h000,8'h00,0, 1,9'h000,9'h001);
        vecs[52] = mk(0,0,INC,0,9'h000,8'h00,0, 0,9'h001,9'h000);
        vecs[53] = mk(0,0,INC,0,9'h000,8'h00,0, 1,9'h000,9'h001);

        drive(1, 0, INC, 0, 9'h000, 8'h00, 0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].stall, vecs[i].sel, vecs[i].call, vecs[i].ja, vecs[i].pcl, vecs[i].skp);
            #1;
            check_outputs(i, vecs[i].stall, vecs[i].v, vecs[i].epc, vecs[i].addr);
        end

        // Reset must win over a simultaneous stall and a redirect request.
        @(negedge clk);
        drive(1, 1, JMP, 1, 9'h0AA, 8'h00, 0);
        @(negedge clk);
        drive(0, 0, INC, 0, 9'h000, 8'h00, 0);
        #1;
        check_outputs(100, 1'b0, 1'b0, 9'h000, 9'h1FF);
        @(negedge clk);
        #1;
        check_outputs(101, 1'b0, 1'b1, 9'h1FF, 9'h000);
        @(negedge clk);
        #1;
        check_outputs(102, 1'b0, 1'b1, 9'h000, 9'h001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icepic_fetch_unit.md
Name: icepic_fetch_unit

Overview:
- Instruction-fetch and program-counter stage of the iCEPIC baseline (12-bit instruction) core.
- Drives the synchronous program-memory port and presents the fetched instruction word, together with its address, to the decode/execute stage.
- Applies the execute stage's PC-update command (the `pc_update_sel_t` encoding) and skip request.
- Owns the 2-level hardware call/return stack and flushes the fetched slot whenever the flow is redirected.

Parameters:
- PC_WIDTH, 9, program-counter and program-memory address width.
- RESET_VECTOR, 9'h1FF, first fetch address after reset (last word of memory, baseline convention).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold entire stage (no PC, stack, or slot change).
- imem_addr  out  PC_WIDTH  program-memory read address; always equals fetch_pc.
- imem_en  out  1  memory read enable; equals ~stall.
- imem_rdata  in  12  read data, valid one cycle after the address (iCE40 BRAM). Memory holds its output while imem_en=0.
- inst_out  out  12  instruction in execute slot; 12'h000 (NOP) when inst_valid=0.
- inst_valid  out  1  execute slot holds a real instruction.
- exec_pc  out  PC_WIDTH  address of inst_out.
- pc_update_sel  in  2  0 INC, 1 JUMP, 2 RET, 3 PCL_MOD; applies to the current execute-slot instruction.
- jump_is_call  in  1  with JUMP: push return address (CALL).
- jump_addr  in  PC_WIDTH  JUMP target from decoder.
- pcl_wdata  in  8  value written to PCL (for PCL_MOD).
- skip  in  1  discard next instruction (BTFSC/BTFSS/DECFSZ/INCFSZ taken).

Behaviour:
- Internal registers: fetch_pc, exec_pc, flush_q, stack1, stack2.
- Output decode: inst_valid = ~flush_q; inst_out = flush_q ? 12'h000 : imem_rdata.
- Reset (rst=1 at an edge, overrides stall and all inputs):
  - fetch_pc=RESET_VECTOR, exec_pc=0, flush_q=1, stack1=stack2=0.
  - Outputs during/after reset: inst_valid=0, inst_out=000, imem_addr=RESET_VECTOR.
  - Reset mid-redirect discards the redirect.
- stall=1: every register is held, imem_en=0, outputs are stable. Control inputs are ignored.
- When stall=0, each edge does: exec_pc<=fetch_pc; flush_q<=redirect|(skip_eff); fetch_pc<=next_pc.
- Control inputs are qualified by inst_valid. When inst_valid=0, treat pc_update_sel as INC with skip=0 and jump_is_call=0.
- next_pc selection (qualified):
  - INC: fetch_pc+1, wrapping modulo 2^PC_WIDTH (1FF -> 000).
  - JUMP, jump_is_call=0 (GOTO): jump_addr.
  - JUMP, jump_is_call=1 (CALL): {1'b0, jump_addr[7:0]}. Also stack2<=stack1; stack1<=exec_pc+1 (wrapping).
  - RET (RETLW): stack1. Also stack1<=stack2; stack2 unchanged.
  - PCL_MOD: {1'b0, pcl_wdata}.
- redirect = qualified sel != INC. Redirect latency: the target's instruction appears with inst_valid=1 two edges after the redirecting instruction executes. Exactly one bubble slot is inserted.
- skip_eff = qualified skip & (sel==INC). If skip and a redirect occur together, the redirect wins and skip is ignored.
- On skip, fetch_pc still increments. The slot holding exec_pc+1 is flushed, and the next valid instruction is exec_pc+2.
- Stack boundary cases:
  - Third nested CALL silently discards the oldest entry in stack2.
  - RET with no prior CALL returns the current stack1 (0 after reset).
  - No over/underflow flags.
- Straight-line throughput: 1 instruction/cycle. exec_pc increments by 1 per valid instruction.

Test Plan:
- Reset then run, memory all NOP:
  - Cycle 1 after release: imem_addr=1FF, inst_valid=0.
  - Cycle 2: inst_valid=1, exec_pc=1FF.
  - Cycle 3: exec_pc=000 (wrap).
- GOTO at 0x005, jump_addr=0x123: the next slot is a bubble (inst_valid=0, inst_out=000); the following slot has exec_pc=0x123.
- CALL at 0x010 (jump_addr=0x1AB) -> executes at 0x0AB (bit 8 cleared), stack1=0x011. RET there -> resumes at exec_pc=0x011 after one bubble.
- Three nested CALLs from 0x020, 0x030, 0x040 (stack1=0x041, stack2=0x031, 0x021 lost), then three RETs -> returns to 0x041, 0x031, then 0x031 again (stack2 is not cleared by pop).
- Skip at 0x050 -> 0x051 slot is invalid, next valid exec_pc=0x052. Skip with simultaneous GOTO 0x100 -> goes to 0x100, and the skip has no effect.
- stall held 3 cycles mid-stream -> inst_out/exec_pc/imem_addr are unchanged and imem_en=0. PCL_MOD with pcl_wdata=0x80 at 0x150 -> exec_pc=0x080. rst asserted during a bubble -> back to RESET_VECTOR and stacks cleared.
